// File: rtl/stack_op_sequencer_pkg.sv
// Shared opcodes, FSM states and operation-class helpers
// for the stack instruction sequencer.
package stack_op_sequencer_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSHI = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_AND   = 3'd5;
    localparam logic [2:0] OP_OR    = 3'd6;
    localparam logic [2:0] OP_NOT   = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        RD_B,
        POP_B,
        RD_A,
        POP_A,
        EXEC,
        PUSH_R,
        DONE
    } state_t;

    function automatic logic is_binary(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_OR);
    endfunction

    // Ops that consume exactly one stack entry
    function automatic logic is_unary(input logic [2:0] op);
        return (op == OP_POP) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/stack_op_sequencer_if.sv
// Instruction valid/ready handshake into the sequencer.
// Master issues instructions, slave is the sequencer.
interface stack_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_imm;

    modport master (
        output op_valid,
        output op_code,
        output op_imm,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_code,
        input  op_imm,
        output op_ready
    );
endinterface

// File: rtl/stack_op_sequencer_alu.sv
// Combinational ALU used in the EXEC step.
// opa is the deeper operand, opb the former top.
module stack_alu
    import stack_op_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             carry
);
    logic [WIDTH:0] sum;

    always_comb begin
        sum   = '0;
        res   = '0;
        carry = 1'b0;
        unique case (op)
            OP_ADD: begin
                sum   = {1'b0, opa} + {1'b0, opb};
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            // carry set means no borrow
            OP_SUB: begin
                sum   = {1'b0, opa} + {1'b0, ~opb} + (WIDTH+1)'(1);
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_AND: res = opa & opb;
            OP_OR:  res = opa | opb;
            OP_NOT: res = ~opb;
            default: ;
        endcase
    end
endmodule

// File: rtl/stack_op_sequencer.sv
// Multicycle sequencer driving an 8-entry Stack's strobes,
// with occupancy tracking and under/overflow rejection.
module stack_op_sequencer
    import stack_op_sequencer_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    stack_op_sequencer_if.slave opif,
    input  logic [WIDTH-1:0]   stk_dout,
    output logic [WIDTH-1:0]   stk_din,
    output logic               stk_push,
    output logic               stk_pop,
    output logic               stk_tos,
    output logic               done,
    output logic               err,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               carry,
    output logic [CNT_W-1:0]   count
);
    state_t           state, nxt;
    logic [2:0]       op_q;
    logic             err_q;
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             accept;
    logic             rej;

    stack_alu #(.WIDTH(WIDTH)) u_alu (
        .opa   (opa),
        .opb   (opb),
        .op    (op_q),
        .res   (alu_res),
        .carry (alu_carry)
    );

    assign accept = opif.op_valid && (state == IDLE);

    // Rejection is judged on the occupancy seen at acceptance
    assign rej =
        (is_binary(opif.op_code) && (count < CNT_W'(2))) ||
        (is_unary(opif.op_code) && (count == '0)) ||
        ((opif.op_code == OP_PUSHI) &&
         (count == CNT_W'(DEPTH)));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt           = state;
        opif.op_ready = 1'b0;
        stk_tos       = 1'b0;
        stk_pop       = 1'b0;
        stk_push      = 1'b0;
        stk_din       = '0;
        done          = 1'b0;
        err           = 1'b0;
        unique case (state)
            IDLE: begin
                opif.op_ready = 1'b1;
                if (accept) begin
                    if (rej || opif.op_code == OP_NOP)
                        nxt = DONE;
                    else if (opif.op_code == OP_PUSHI)
                        nxt = PUSH_R;
                    else
                        nxt = RD_B;
                end
            end
            RD_B: begin
                stk_tos = 1'b1;
                nxt     = POP_B;
            end
            POP_B: begin
                stk_pop = 1'b1;
                if (is_binary(op_q))     nxt = RD_A;
                else if (op_q == OP_NOT) nxt = EXEC;
                else                     nxt = DONE;
            end
            RD_A: begin
                stk_tos = 1'b1;
                nxt     = POP_A;
            end
            POP_A: begin
                stk_pop = 1'b1;
                nxt     = EXEC;
            end
            EXEC: nxt = PUSH_R;
            PUSH_R: begin
                stk_push = 1'b1;
                stk_din  = result;
                nxt      = DONE;
            end
            DONE: begin
                done = 1'b1;
                err  = err_q;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_NOP;
            err_q  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            count  <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    op_q  <= opif.op_code;
                    err_q <= rej;
                    // PUSHI result is staged so PUSH_R can drive it
                    if (!rej && opif.op_code == OP_PUSHI) begin
                        result <= opif.op_imm;
                        zero   <= (opif.op_imm == '0);
                        carry  <= 1'b0;
                    end
                end
                RD_B: begin
                    opb <= stk_dout;
                    if (op_q == OP_POP) begin
                        result <= stk_dout;
                        zero   <= (stk_dout == '0);
                        carry  <= 1'b0;
                    end
                end
                RD_A:   opa   <= stk_dout;
                POP_B:  count <= count - CNT_W'(1);
                POP_A:  count <= count - CNT_W'(1);
                EXEC: begin
                    result <= alu_res;
                    zero   <= (alu_res == '0);
                    carry  <= alu_carry;
                end
                PUSH_R: count <= count + CNT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: behavioural Stack, queue-based
// reference model, directed plus random instruction stream.
module tb_stack_op_sequencer;
    import stack_op_sequencer_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] stk_dout, stk_din, result;
    logic             stk_push, stk_pop, stk_tos;
    logic             done, err, zero, carry;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    stack_op_sequencer_if #(.WIDTH(WIDTH)) opif ();

    stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .opif     (opif),
        .stk_dout (stk_dout),
        .stk_din  (stk_din),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_tos  (stk_tos),
        .done     (done),
        .err      (err),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .count    (count)
    );

    // Behavioural Stack the sequencer drives
    logic [7:0] mem [DEPTH];
    int         sp;
    logic [2:0] top_i;
    assign top_i    = 3'(sp - 1);
    assign stk_dout = (stk_tos && sp > 0) ? mem[top_i] : 8'hA5;

    always @(posedge clk) begin
        if (rst) sp <= 0;
        else if (stk_push && sp < DEPTH) begin
            mem[sp[2:0]] <= stk_din;
            sp <= sp + 1;
        end else if (stk_pop && sp > 0) sp <= sp - 1;
    end

    // Reference model
    logic [7:0] q[$];
    logic [7:0] m_res;
    logic       m_zero, m_carry;

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] code, input logic [7:0] imm,
                          input bit hold);
        logic [7:0] a, b, pd, e_pd;
        int   e_lat, e_tr, tr, lat, n, s;
        bit   e_err, multi, busy, seen;
        e_err = 1'b0; e_lat = 1; e_tr = 0; e_pd = 8'h00;
        case (code)
            OP_NOP: ;
            OP_PUSHI:
                if (q.size() == DEPTH) e_err = 1'b1;
                else begin
                    q.push_back(imm);
                    m_res = imm; m_carry = 1'b0;
                    e_lat = 2; e_tr = 3; e_pd = imm;
                end
            OP_POP:
                if (q.size() == 0) e_err = 1'b1;
                else begin
                    m_res = q.pop_back(); m_carry = 1'b0;
                    e_lat = 3; e_tr = 1 * 4 + 2;
                end
            OP_NOT:
                if (q.size() == 0) e_err = 1'b1;
                else begin
                    b = q.pop_back();
                    m_res = ~b; m_carry = 1'b0;
                    q.push_back(m_res);
                    e_lat = 5; e_tr = (1 * 4 + 2) * 4 + 3; e_pd = m_res;
                end
            default:
                if (q.size() < 2) e_err = 1'b1;
                else begin
                    b = q.pop_back();
                    a = q.pop_back();
                    s = int'(a) + int'(b);
                    m_carry = 1'b0;
                    case (code)
                        OP_ADD: begin m_res = 8'(s); m_carry = (s > 255); end
                        OP_SUB: begin m_res = a - b; m_carry = (a >= b); end
                        OP_AND: m_res = a & b;
                        default: m_res = a | b;
                    endcase
                    q.push_back(m_res);
                    e_lat = 7; e_pd = m_res;
                    e_tr = (((1 * 4 + 2) * 4 + 1) * 4 + 2) * 4 + 3;
                end
        endcase
        if (code != OP_NOP && !e_err) m_zero = (m_res == 8'h00);

        opif.op_valid = 1'b1;
        opif.op_code  = code;
        opif.op_imm   = imm;
        n = 0;
        while (!opif.op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 32'(opif.op_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs: captured values must be used
        opif.op_code = 3'($urandom);
        opif.op_imm  = 8'($urandom);
        if (!hold) opif.op_valid = 1'b0;

        lat = 0; tr = 0; multi = 0; busy = 0; seen = 0; pd = 8'h00;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (int'(stk_tos) + int'(stk_pop) + int'(stk_push) > 1) multi = 1;
            if (stk_tos)      tr = tr * 4 + 1;
            else if (stk_pop) tr = tr * 4 + 2;
            else if (stk_push) begin tr = tr * 4 + 3; pd = stk_din; end
            if (opif.op_ready) busy = 1;
            if (done) seen = 1;
        end
        check("done_seen",   32'(seen),    32'd1);
        check("latency",     32'(lat),     32'(e_lat));
        check("strobe_seq",  32'(tr),      32'(e_tr));
        check("strobe_1hot", 32'(multi),   32'd0);
        check("busy_ready",  32'(busy),    32'd0);
        check("err",         32'(err),     32'(e_err));
        check("result",      32'(result),  32'(m_res));
        check("zero",        32'(zero),    32'(m_zero));
        check("carry",       32'(carry),   32'(m_carry));
        check("count",       32'(count),   32'(q.size()));
        if (e_pd != 8'h00 || e_tr % 4 == 3)
            check("push_din", 32'(pd), 32'(e_pd));
        @(negedge clk);
        check("done_1cyc", 32'({done, opif.op_ready}), 32'b01);
    endtask

    initial begin
        rst = 1'b1;
        opif.op_valid = 1'b0;
        opif.op_code  = OP_NOP;
        opif.op_imm   = 8'h00;
        m_res = 8'h00; m_zero = 1'b0; m_carry = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state",
              32'({opif.op_ready, done, err, stk_push, stk_pop, stk_tos}),
              32'b100000);
        check("rst_count",  32'(count),  32'd0);
        check("rst_result", 32'({result, zero, carry}), 32'd0);
        check("rst_din",    32'(stk_din), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(OP_PUSHI, 8'h3C, 0);
        run_op(OP_PUSHI, 8'h30, 0);
        run_op(OP_ADD,   8'h00, 0);
        run_op(OP_PUSHI, 8'h05, 0);
        run_op(OP_PUSHI, 8'h07, 0);
        run_op(OP_SUB,   8'h00, 0);
        run_op(OP_PUSHI, 8'h02, 0);
        run_op(OP_SUB,   8'h00, 0);
        while (q.size() > 0) run_op(OP_POP, 8'h00, 0);
        run_op(OP_POP, 8'h00, 0);
        run_op(OP_NOT, 8'h00, 0);
        run_op(OP_ADD, 8'h00, 0);
        run_op(OP_PUSHI, 8'h11, 0);
        run_op(OP_OR,  8'h00, 0);
        for (int i = 0; i < DEPTH; i++) run_op(OP_PUSHI, 8'($urandom), 0);
        run_op(OP_PUSHI, 8'h99, 0);
        run_op(OP_NOP,   8'h00, 0);
        while (q.size() > 0) run_op(OP_POP, 8'h00, 0);
        run_op(OP_PUSHI, 8'hFF, 1);
        run_op(OP_NOT,   8'h00, 1);
        run_op(OP_PUSHI, 8'h00, 0);

        // Reset while the ADD sits in RD_A
        run_op(OP_PUSHI, 8'h21, 0);
        opif.op_valid = 1'b1;
        opif.op_code  = OP_ADD;
        @(posedge clk);
        #1 opif.op_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rda_tos", 32'(stk_tos), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_res = 8'h00; m_zero = 1'b0; m_carry = 1'b0;
        @(negedge clk);
        check("abort_state",
              32'({opif.op_ready, done, stk_push, stk_pop, stk_tos}),
              32'b10000);
        check("abort_count", 32'(count), 32'd0);
        begin
            bit dseen = 0;
            repeat (8) begin
                @(negedge clk);
                if (done) dseen = 1;
            end
            check("abort_no_done", 32'(dseen), 32'd0);
        end

        for (int i = 0; i < 60; i++) begin
            logic [2:0] c;
            c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) c = OP_PUSHI;
            run_op(c, 8'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
